// File: rtl/oscill_pkg.sv
// Shared types and constants for the oscilloscope capture/render front stage.
package oscill_pkg;

  typedef enum logic [1:0] {ARM, CAPTURE, SHOW, WAIT} state_e;

  localparam int H_ACT = 640;
  localparam int V_ACT = 480;

  localparam logic [15:0] RGB_BLACK  = 16'h0000;
  localparam logic [15:0] RGB_YELLOW = 16'hFFE0;
  localparam logic [15:0] RGB_GREY   = 16'h8410;

  // y mod 60 without a divider: 64*a + b == 4*a + b (mod 60), then at most two subtracts.
  function automatic logic [5:0] row_mod60(input logic [10:0] y);
    logic [7:0] r;
    r = {1'b0, y[10:6], 2'b00} + {2'b00, y[5:0]};
    if (r >= 8'd120) r = r - 8'd120;
    if (r >= 8'd60)  r = r - 8'd60;
    return r[5:0];
  endfunction

endpackage

// File: rtl/oscill_sample_ram.sv
// Simple dual-port sample buffer: one write port, one registered read port (block-RAM friendly).
module oscill_sample_ram #(
  parameter int DW    = 8,
  parameter int DEPTH = 640,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_rdata;

  // NOTE: the storage array has no reset; resetting it would prevent block-RAM inference.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/oscill_wave_render.sv
// Oscilloscope front stage: triggered capture of one record, rendered as a trace for the VGA driver.
// Define OSCILL_GRID_EN to overlay a graticule behind the trace.
module oscill_wave_render
  import oscill_pkg::*;
#(
  parameter int            DW        = 8,
  parameter int            DEPTH     = H_ACT,
  parameter int            DECIM     = 1,
  parameter logic [DW-1:0] TRIG_LVL  = DW'(128),
  parameter logic [19:0]   AUTO_TO   = 20'd500000,
  parameter int            Y_BASE    = 367,
  parameter logic [15:0]   COL_TRACE = RGB_YELLOW,
  parameter logic [15:0]   COL_GRID  = RGB_GREY
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] adc_data,
  input  logic          adc_vld,
  input  logic [10:0]   vga_x,
  input  logic [10:0]   vga_y,
  input  logic          vga_rdy,
  output logic [15:0]   din,
  output logic          din_en,
  output logic          trig_seen
);

  localparam int            AW        = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [10:0]   DEC_LAST  = 11'(DECIM - 1);

  state_e        r_state, w_next;
  logic [DW-1:0] r_prev;
  logic [19:0]   r_tmo_cnt;
  logic [10:0]   r_dec_cnt;
  logic [AW-1:0] r_waddr;
  logic          r_trig_seen;

  logic          w_vld_arm, w_cross, w_tmo, w_start, w_cap_wr, w_last;
  logic          w_we;
  logic [AW-1:0] w_wa;

  assign w_vld_arm = (r_state == ARM) && adc_vld;
  assign w_cross   = (r_prev < TRIG_LVL) && (adc_data >= TRIG_LVL);
  assign w_tmo     = (r_tmo_cnt == AUTO_TO - 20'd1);
  assign w_start   = w_vld_arm && (w_cross || w_tmo);
  assign w_cap_wr  = (r_state == CAPTURE) && adc_vld && (r_dec_cnt == 11'd0);
  assign w_last    = w_cap_wr && (r_waddr == LAST_ADDR);

  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ARM;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ARM:     if (w_start) w_next = CAPTURE;
      CAPTURE: if (w_last)  w_next = SHOW;
      SHOW:                 w_next = WAIT;
      WAIT:    if (vga_rdy) w_next = ARM;
      default:              w_next = ARM;
    endcase
  end

  // NOTE: every output gets a default before the case, so no path can infer a latch.
  always_comb begin
    din_en = 1'b0;
    w_we   = 1'b0;
    w_wa   = r_waddr;
    case (r_state)
      ARM: begin
        w_we = w_start;
        w_wa = '0;
      end
      CAPTURE: w_we   = w_cap_wr;
      SHOW:    din_en = 1'b1;
      default: ;
    endcase
  end

  // The trigger sample occupies decimation slot 0, so the next store lands DECIM samples later.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev      <= '0;
      r_tmo_cnt   <= '0;
      r_dec_cnt   <= '0;
      r_waddr     <= '0;
      r_trig_seen <= 1'b0;
    end else begin
      if (w_vld_arm) begin
        r_prev <= adc_data;
        if (!w_start) r_tmo_cnt <= r_tmo_cnt + 20'd1;
      end
      if (w_start) begin
        r_trig_seen <= w_cross;
        r_waddr     <= AW'(1);
        r_dec_cnt   <= (DECIM == 1) ? 11'd0 : 11'd1;
      end
      if ((r_state == CAPTURE) && adc_vld) begin
        r_dec_cnt <= (r_dec_cnt == DEC_LAST) ? 11'd0 : r_dec_cnt + 11'd1;
        if (w_cap_wr) r_waddr <= r_waddr + AW'(1);
      end
      if ((r_state == WAIT) && vga_rdy) r_tmo_cnt <= '0;
    end
  end

  assign trig_seen = r_trig_seen;

  logic [AW-1:0] w_raddr;
  logic [DW-1:0] w_rd;

  assign w_raddr = (vga_x >= 11'(DEPTH)) ? LAST_ADDR : vga_x[AW-1:0];

  oscill_sample_ram #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_wa),
    .i_wdata (adc_data),
    .i_raddr (w_raddr),
    .o_rdata (w_rd)
  );

  // Stage-1 alignment: coordinates and the previous column's sample travel beside the RAM read.
  logic [10:0]   r_x1, r_y1;
  logic [DW-1:0] r_rd_prev;

  always_ff @(posedge clk) begin
    r_x1      <= vga_x;
    r_y1      <= vga_y;
    r_rd_prev <= w_rd;
  end

  logic [10:0] w_cur, w_prv, w_lo, w_hi;
  logic        w_trace, w_grid;

  assign w_cur   = 11'(Y_BASE) - 11'(w_rd);
  assign w_prv   = (r_x1 == 11'd0) ? w_cur : 11'(Y_BASE) - 11'(r_rd_prev);
  assign w_lo    = (w_cur < w_prv) ? w_cur : w_prv;
  assign w_hi    = (w_cur < w_prv) ? w_prv : w_cur;
  assign w_trace = (r_y1 >= w_lo) && (r_y1 <= w_hi);

`ifdef OSCILL_GRID_EN
  assign w_grid = (r_x1[5:0] == 6'd0) || (row_mod60(r_y1) == 6'd0) ||
                  (r_x1 == 11'(H_ACT - 1)) || (r_y1 == 11'(V_ACT - 1));
`else
  assign w_grid = 1'b0;
`endif

  logic [15:0] r_din;

  always_ff @(posedge clk) begin
    if (rst)          r_din <= RGB_BLACK;
    else if (w_trace) r_din <= COL_TRACE;
    else if (w_grid)  r_din <= COL_GRID;
    else              r_din <= RGB_BLACK;
  end

  assign din = r_din;

endmodule

// File: tb/tb_oscill_wave_render.sv
// Bench for oscill_wave_render: random captures checked against a sample-list reference model.
`timescale 1ns/1ps
module tb_oscill_wave_render;

  localparam int YB   = 367;
  localparam int TLVL = 128;
  localparam int ATO  = 1000;
  localparam int NCOL = 640;

  logic        clk      = 1'b0;
  logic        rst      = 1'b1;
  logic [7:0]  adc_data = '0;
  logic        adc_vld  = 1'b0;
  logic [10:0] vga_x    = '0;
  logic [10:0] vga_y    = '0;
  logic        vga_rdy  = 1'b0;
  logic        sel      = 1'b0;

  logic [15:0] din1, din4, w_din;
  logic        en1, en4, tr1, tr4, w_en, w_trig;
  logic        vld1, vld4, rdy1, rdy4;

  assign vld1   = adc_vld & ~sel;
  assign vld4   = adc_vld & sel;
  assign rdy1   = vga_rdy & ~sel;
  assign rdy4   = vga_rdy & sel;
  assign w_din  = sel ? din4 : din1;
  assign w_en   = sel ? en4 : en1;
  assign w_trig = sel ? tr4 : tr1;

  oscill_wave_render #(.DECIM(1), .AUTO_TO(20'd1000)) u_dut1 (
    .clk(clk), .rst(rst), .adc_data(adc_data), .adc_vld(vld1),
    .vga_x(vga_x), .vga_y(vga_y), .vga_rdy(rdy1),
    .din(din1), .din_en(en1), .trig_seen(tr1)
  );

  oscill_wave_render #(.DECIM(4), .AUTO_TO(20'd1000)) u_dut4 (
    .clk(clk), .rst(rst), .adc_data(adc_data), .adc_vld(vld4),
    .vga_x(vga_x), .vga_y(vga_y), .vga_rdy(rdy4),
    .din(din4), .din_en(en4), .trig_seen(tr4)
  );

  always #20 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int stim[$];
  int exp_buf[NCOL];

  // Index of the sample that starts the capture, counted from entry into ARM.
  function automatic int model_trig();
    for (int i = 0; i < stim.size(); i++) begin
      if (i > 0 && stim[i-1] < TLVL && stim[i] >= TLVL) return i;
      if (i == ATO - 1) return i;
    end
    return -1;
  endfunction

  function automatic logic [15:0] exp_pix(input int x, input int y);
    int cur, prv;
    bit grid;
    cur = YB - exp_buf[x];
    prv = (x == 0) ? cur : YB - exp_buf[x-1];
    if ((y >= cur || y >= prv) && (y <= cur || y <= prv)) return 16'hFFE0;
    grid = 1'b0;
`ifdef OSCILL_GRID_EN
    grid = (x % 64 == 0) || (y % 60 == 0) || (x == 639) || (y == 479);
`endif
    return grid ? 16'h8410 : 16'h0000;
  endfunction

  task automatic feed(input int stop, input int rdy_at, output int fed, output bit seen);
    int cyc;
    cyc  = 0;
    fed  = 0;
    seen = 1'b0;
    while (fed < stop && !seen && cyc < 20000) begin
      adc_vld  = ($urandom_range(0, 3) != 0);
      adc_data = 8'(stim[fed]);
      vga_rdy  = (fed == rdy_at);
      @(negedge clk);
      if (adc_vld) fed++;
      if (w_en) seen = 1'b1;
      cyc++;
    end
    adc_vld = 1'b0;
    vga_rdy = 1'b0;
  endtask

  task automatic run_capture(input string name, input int rdy_off);
    int ti, last, fed, decim;
    bit seen, exp_trig;
    decim = sel ? 4 : 1;
    ti    = model_trig();
    last  = ti + (NCOL - 1) * decim;
    if (ti < 0 || last >= stim.size()) begin
      $display("FAIL %s stimulus too short: trigger=%0d last=%0d size=%0d", name, ti, last, stim.size());
      $fatal(1);
    end
    exp_trig = (ti > 0) && (stim[ti-1] < TLVL) && (stim[ti] >= TLVL);
    for (int k = 0; k < NCOL; k++) exp_buf[k] = stim[ti + k * decim];
    feed(stim.size(), (rdy_off < 0) ? -1 : ti + rdy_off, fed, seen);
    n_tests++;
    if (seen !== 1'b1) begin
      n_fail++;
      $display("FAIL %s din_en: got no pulse, wanted one", name);
    end
    n_tests++;
    if (fed !== last + 1) begin
      n_fail++;
      $display("FAIL %s sample count at din_en: got %0d want %0d", name, fed, last + 1);
    end
    n_tests++;
    if (w_trig !== exp_trig) begin
      n_fail++;
      $display("FAIL %s trig_seen: got %b want %b", name, w_trig, exp_trig);
    end
    @(negedge clk);
    n_tests++;
    if (w_en !== 1'b0) begin
      n_fail++;
      $display("FAIL %s din_en width: got %b want 0 on second cycle", name, w_en);
    end
  endtask

  task automatic probe(input int x, input int y, input string name);
    logic [15:0] exp;
    vga_y = 11'(y);
    vga_x = 11'((x > 0) ? x - 1 : 0);
    @(negedge clk);
    vga_x = 11'(x);
    @(negedge clk);
    vga_x = '0;
    @(negedge clk);
    exp = exp_pix(x, y);
    n_tests++;
    if (w_din !== exp) begin
      n_fail++;
      $display("FAIL %s x=%0d y=%0d: din=%h want %h", name, x, y, w_din, exp);
    end
  endtask

  task automatic scan_row(input int y, input string name);
    logic [15:0] exp;
    vga_y = 11'(y);
    for (int c = 0; c <= NCOL; c++) begin
      vga_x = 11'((c < NCOL) ? c : 0);
      @(negedge clk);
      if (c >= 1) begin
        exp = exp_pix(c - 1, y);
        n_tests++;
        if (w_din !== exp) begin
          n_fail++;
          $display("FAIL %s x=%0d y=%0d: din=%h want %h", name, c - 1, y, w_din, exp);
        end
      end
    end
  endtask

  task automatic release_wait();
    vga_rdy = 1'b1;
    @(negedge clk);
    vga_rdy = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      n_tests++;
      if (w_din !== 16'h0000) begin n_fail++; $display("FAIL reset din[%0d]: got %h want 0000", s, w_din); end
      n_tests++;
      if (w_en !== 1'b0) begin n_fail++; $display("FAIL reset din_en[%0d]: got %b want 0", s, w_en); end
      n_tests++;
      if (w_trig !== 1'b0) begin n_fail++; $display("FAIL reset trig_seen[%0d]: got %b want 0", s, w_trig); end
    end
    sel = 1'b0;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ramp_trigger();
    sel = 1'b0;
    stim.delete();
    for (int i = 0; i < 1200; i++) stim.push_back(i % 256);
    run_capture("ramp", -1);
    probe(0, YB - 128, "ramp_col0");
    probe(128, YB, "ramp_wrap_bottom");
    probe(128, 111, "ramp_wrap_above");
    repeat (4) begin
      int k;
      k = $urandom_range(1, NCOL - 1);
      probe(k, YB - ((128 + k) % 256), "ramp_cur");
    end
    scan_row(YB - 200, "ramp_row");
  endtask

  task automatic test_wait_ignores();
    int pulses;
    pulses = 0;
    for (int i = 0; i < 200; i++) begin
      adc_vld  = 1'b1;
      adc_data = (i % 2 == 1) ? 8'd200 : 8'd0;
      @(negedge clk);
      if (w_en) pulses++;
    end
    adc_vld = 1'b0;
    n_tests++;
    if (pulses !== 0) begin n_fail++; $display("FAIL wait din_en pulses: got %0d want 0", pulses); end
    scan_row(YB - 150, "wait_row");
    release_wait();
  endtask

  task automatic test_auto_timeout();
    stim.delete();
    for (int i = 0; i < 1700; i++) stim.push_back(50);
    run_capture("auto", -1);
    scan_row(317, "auto_row317");
    scan_row(316, "auto_row316");
    scan_row(318, "auto_row318");
    probe(10, 317, "x10_y317");
    probe(10, 300, "x10_y300");
    release_wait();
  endtask

  task automatic test_steep_edge();
    stim.delete();
    stim.push_back(0);
    stim.push_back(128);
    for (int k = 1; k < NCOL + 10; k++) stim.push_back($urandom_range(0, 255));
    stim[1 + 99]  = 0;
    stim[1 + 100] = 255;
    run_capture("steep", -1);
    probe(100, 111, "steep_r111");
    probe(100, 112, "steep_r112");
    probe(100, 240, "steep_r240");
    probe(100, 367, "steep_r367");
    probe(100, 368, "steep_r368");
    scan_row($urandom_range(112, 367), "steep_row");
    release_wait();
  endtask

  task automatic test_rdy_ignored();
    stim.delete();
    for (int i = 0; i < 1200; i++) stim.push_back(i % 256);
    run_capture("rdy_in_capture", 200);
    scan_row(YB - 100, "rdy_row");
    release_wait();
  endtask

  task automatic test_reset_mid_capture();
    int fed, ti;
    bit seen;
    stim.delete();
    for (int i = 0; i < 1200; i++) stim.push_back(i % 256);
    ti    = model_trig();
    vga_x = '0;
    vga_y = 11'(YB - 128);
    feed(ti + 300, -1, fed, seen);
    n_tests++;
    if (seen !== 1'b0) begin n_fail++; $display("FAIL midrst early din_en: got %b want 0", seen); end
    n_tests++;
    if (w_din !== 16'hFFE0) begin n_fail++; $display("FAIL midrst pre-reset din: got %h want ffe0", w_din); end
    rst = 1'b1;
    @(negedge clk);
    n_tests++;
    if (w_din !== 16'h0000) begin n_fail++; $display("FAIL midrst din: got %h want 0000", w_din); end
    n_tests++;
    if (w_en !== 1'b0) begin n_fail++; $display("FAIL midrst din_en: got %b want 0", w_en); end
    n_tests++;
    if (w_trig !== 1'b0) begin n_fail++; $display("FAIL midrst trig_seen: got %b want 0", w_trig); end
    @(negedge clk);
    rst = 1'b0;
    stim.delete();
    for (int i = 0; i < 500; i++) stim.push_back(50);
    for (int i = 0; i < 1200; i++) stim.push_back(i % 256);
    run_capture("after_rst", -1);
    scan_row($urandom_range(112, 367), "after_rst_row");
    release_wait();
  endtask

  task automatic test_decim();
    sel = 1'b1;
    stim.delete();
    stim.push_back(0);
    for (int i = 1; i < 3600; i++) stim.push_back($urandom_range(0, 255));
    run_capture("decim4", -1);
    repeat (2) scan_row($urandom_range(112, 367), "decim_row");
    repeat (4) begin
      int k;
      k = $urandom_range(0, NCOL - 1);
      probe(k, YB - exp_buf[k], "decim_cur");
    end
    release_wait();
    sel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_ramp_trigger();
    test_wait_ignores();
    test_auto_timeout();
    test_steep_edge();
    test_rdy_ignored();
    test_reset_mid_capture();
    test_decim();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
